// File: rtl/rab_lookup_pkg.sv
// Shared types for the multi-port lookup result queue: occupancy states and
// the per-entry verdict record.
package rab_lookup_pkg;

  localparam int unsigned PORT_IDX_W = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_e;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] port;
    logic                  accept;
    logic                  drop;
    logic                  miss;
    logic                  multi;
    logic                  prot;
    logic                  prefetch;
    logic                  cache_coherent;
  } lookup_result_t;

  function automatic lookup_result_t make_result(
    input logic [PORT_IDX_W-1:0] port,
    input logic no_hit, multi_hit, no_prot, prefetch, cache_coherent
  );
    lookup_result_t r;
    r.port           = port;
    r.drop           = no_hit | multi_hit | ~no_prot | prefetch;
    r.accept         = ~r.drop;
    r.miss           = no_hit;
    r.multi          = multi_hit;
    r.prot           = ~no_prot;
    r.prefetch       = ~no_hit & prefetch;
    r.cache_coherent = cache_coherent;
    return r;
  endfunction

endpackage

// File: rtl/lookup_fsm_mp_if.sv
// Request/result bundle between the slave ports and the shared lookup queue.
interface lookup_fsm_mp_if #(
  parameter int unsigned NUM_PORTS        = 2,
  parameter int unsigned DEPTH            = 2,
  parameter int unsigned AXI_M_ADDR_WIDTH = 40,
  parameter int unsigned AXI_S_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH     = 8,
  parameter int unsigned AXI_USER_WIDTH   = 6
);
  logic [NUM_PORTS-1:0]          port_addr_valid_i;
  logic [NUM_PORTS-1:0]          port_sent_i;
  logic [$clog2(NUM_PORTS)-1:0]  select_i;
  logic                          invalidate_i, no_hit_i, multi_hit_i, no_prot_i;
  logic                          prefetch_i, cache_coherent_i;
  logic [AXI_M_ADDR_WIDTH-1:0]   out_addr_i;
  logic [AXI_S_ADDR_WIDTH-1:0]   in_addr_i;
  logic [AXI_ID_WIDTH-1:0]       in_id_i;
  logic [7:0]                    in_len_i;
  logic [AXI_USER_WIDTH-1:0]     in_user_i;

  logic                          lookup_ready_o;
  logic [NUM_PORTS-1:0]          port_accept_o, port_drop_o, port_miss_o;
  logic                          miss_o, multi_o, prot_o, prefetch_o, cache_coherent_o;
  logic [AXI_M_ADDR_WIDTH-1:0]   out_addr_o;
  logic [AXI_S_ADDR_WIDTH-1:0]   in_addr_o;
  logic [AXI_ID_WIDTH-1:0]       in_id_o;
  logic [7:0]                    in_len_o;
  logic [AXI_USER_WIDTH-1:0]     in_user_o;
  logic [$clog2(DEPTH+1)-1:0]    pending_o;

  modport master (
    output port_addr_valid_i, port_sent_i, select_i, invalidate_i, no_hit_i,
           multi_hit_i, no_prot_i, prefetch_i, cache_coherent_i, out_addr_i,
           in_addr_i, in_id_i, in_len_i, in_user_i,
    input  lookup_ready_o, port_accept_o, port_drop_o, port_miss_o, miss_o,
           multi_o, prot_o, prefetch_o, cache_coherent_o, out_addr_o,
           in_addr_o, in_id_o, in_len_o, in_user_o, pending_o
  );

  modport slave (
    input  port_addr_valid_i, port_sent_i, select_i, invalidate_i, no_hit_i,
           multi_hit_i, no_prot_i, prefetch_i, cache_coherent_i, out_addr_i,
           in_addr_i, in_id_i, in_len_i, in_user_i,
    output lookup_ready_o, port_accept_o, port_drop_o, port_miss_o, miss_o,
           multi_o, prot_o, prefetch_o, cache_coherent_o, out_addr_o,
           in_addr_o, in_id_o, in_len_o, in_user_o, pending_o
  );
endinterface

// File: rtl/lookup_result_fifo.sv
// In-order store of lookup results; occupancy tracked by an EMPTY/PARTIAL/FULL
// state machine, pointers wrap at DEPTH (any value, not only powers of two).
module lookup_result_fifo
  import rab_lookup_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = logic
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     wdata,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  occ_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  entry_t           mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal written here gets its default first, so no path can leave a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    unique case (state_q)
      OCC_EMPTY:
        if (push) state_d = (DEPTH == 1) ? OCC_FULL : OCC_PARTIAL;
      OCC_PARTIAL: begin
        if (push && !pop && 32'(count_q) == DEPTH - 1) state_d = OCC_FULL;
        if (pop && !push && count_q == CNT_W'(1))      state_d = OCC_EMPTY;
      end
      OCC_FULL:
        if (pop && !push) state_d = (DEPTH == 1) ? OCC_EMPTY : OCC_PARTIAL;
      default: state_d = OCC_EMPTY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= OCC_EMPTY;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are never visible while empty.
  always_ff @(posedge Clk_CI) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (state_q == OCC_FULL);
  assign empty = (state_q == OCC_EMPTY);

endmodule

// File: rtl/lookup_fsm_mp.sv
// Shared lookup stage for several slave ports: captures the selected port's
// lookup result and presents results in order, one-hot on the owning port.
module lookup_fsm_mp
  import rab_lookup_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 2,
  parameter int unsigned DEPTH            = 2,
  parameter int unsigned AXI_M_ADDR_WIDTH = 40,
  parameter int unsigned AXI_S_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH     = 8,
  parameter int unsigned AXI_USER_WIDTH   = 6
) (
  input logic           Clk_CI,
  input logic           Rst_RBI,
  lookup_fsm_mp_if.slave bus
);
  typedef struct packed {
    lookup_result_t              res;
    logic [AXI_M_ADDR_WIDTH-1:0] out_addr;
    logic [AXI_S_ADDR_WIDTH-1:0] in_addr;
    logic [AXI_ID_WIDTH-1:0]     in_id;
    logic [7:0]                  in_len;
    logic [AXI_USER_WIDTH-1:0]   in_user;
  } entry_t;

  entry_t                     wr_entry, head;
  logic                       push, pop, full, empty, sel_legal;
  logic [NUM_PORTS-1:0]       sel_onehot, head_onehot;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Sent on a non-owning port must not pop, so the head's port gates it.
  always_comb begin
    sel_onehot         = NUM_PORTS'(1) << bus.select_i;
    head_onehot        = NUM_PORTS'(1) << head.res.port;
    sel_legal          = 32'(bus.select_i) < NUM_PORTS;
    pop                = !empty && |(bus.port_sent_i & head_onehot);
    bus.lookup_ready_o = !full || pop;
    push               = !bus.invalidate_i && sel_legal && bus.lookup_ready_o &&
                         |(bus.port_addr_valid_i & sel_onehot);
    wr_entry.res       = make_result(PORT_IDX_W'(bus.select_i), bus.no_hit_i,
                                     bus.multi_hit_i, bus.no_prot_i,
                                     bus.prefetch_i, bus.cache_coherent_i);
    wr_entry.out_addr  = bus.out_addr_i;
    wr_entry.in_addr   = bus.in_addr_i;
    wr_entry.in_id     = bus.in_id_i;
    wr_entry.in_len    = bus.in_len_i;
    wr_entry.in_user   = bus.in_user_i;
  end

  lookup_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Head fields are forced to zero while nothing is held.
  assign bus.port_accept_o    = empty ? '0 : NUM_PORTS'(head.res.accept) << head.res.port;
  assign bus.port_drop_o      = empty ? '0 : NUM_PORTS'(head.res.drop) << head.res.port;
  assign bus.port_miss_o      = empty ? '0 : NUM_PORTS'(head.res.miss) << head.res.port;
  assign bus.miss_o           = !empty && head.res.miss;
  assign bus.multi_o          = !empty && head.res.multi;
  assign bus.prot_o           = !empty && head.res.prot;
  assign bus.prefetch_o       = !empty && head.res.prefetch;
  assign bus.cache_coherent_o = !empty && head.res.cache_coherent;
  assign bus.out_addr_o       = empty ? '0 : head.out_addr;
  assign bus.in_addr_o        = empty ? '0 : head.in_addr;
  assign bus.in_id_o          = empty ? '0 : head.in_id;
  assign bus.in_len_o         = empty ? '0 : head.in_len;
  assign bus.in_user_o        = empty ? '0 : head.in_user;
  assign bus.pending_o        = count;

endmodule

// File: doc/lookup_fsm_mp.md
LOOKUP_FSM_MP -- requirements
Module: lookup_fsm_mp

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of slave ports sharing the lookup; legal range 2..8.
REQ-002 SHALL have parameter DEPTH, default 2: outstanding lookup results held; legal range 1..8.
REQ-003 SHALL have parameters AXI_M_ADDR_WIDTH=40, AXI_S_ADDR_WIDTH=32, AXI_ID_WIDTH=8, AXI_USER_WIDTH=6: address, ID and user field widths.
REQ-004 Clk_CI  in  1  sole clock; all state updates on its rising edge.
REQ-005 Rst_RBI  in  1  reset; asynchronous, active-low.
REQ-006 port_addr_valid_i  in  NUM_PORTS  per-port lookup request valid.
REQ-007 port_sent_i  in  NUM_PORTS  per-port: accepted/dropped transaction forwarded, result consumed.
REQ-008 select_i  in  $clog2(NUM_PORTS)  index of the port whose request drives the lookup inputs this cycle.
REQ-009 invalidate_i, no_hit_i, multi_hit_i, no_prot_i, prefetch_i, cache_coherent_i  in  1 each  lookup status.
REQ-010 out_addr_i  in  AXI_M_ADDR_WIDTH; in_addr_i  in  AXI_S_ADDR_WIDTH; in_id_i  in  AXI_ID_WIDTH; in_len_i  in  8; in_user_i  in  AXI_USER_WIDTH: lookup result and request attributes.
REQ-011 lookup_ready_o  out  1  a capture can occur this cycle.
REQ-012 port_accept_o, port_drop_o, port_miss_o  out  NUM_PORTS each  head-result verdict, one-hot on the owning port.
REQ-013 miss_o, multi_o, prot_o, prefetch_o, cache_coherent_o  out  1 each; out_addr_o, in_addr_o, in_id_o, in_len_o, in_user_o  out  input widths: head-result fields.
REQ-014 pending_o  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Capture condition: ~invalidate_i & port_addr_valid_i[select_i] & lookup_ready_o.
REQ-016 lookup_ready_o SHALL be (count < DEPTH) | pop_this_cycle; it SHALL depend combinationally on port_sent_i.
REQ-017 On capture, entry SHALL store port index = select_i, drop = no_hit|multi_hit|~no_prot|prefetch, accept = ~drop, miss = no_hit, multi = multi_hit, prot = ~no_prot, prefetch = ~no_hit & prefetch, plus cache_coherent, out_addr, in_addr, in_id, in_len, in_user.
REQ-018 Entries SHALL be kept in capture order; outputs SHALL show the head entry only, registered, with zero latency from the entry becoming head.
REQ-019 Verdict bits SHALL appear only at bit [port index] of the port_*_o vectors; all other bits 0.
REQ-020 Pop condition: count != 0 & port_sent_i[head port index]; sent on any other port SHALL be ignored.
REQ-021 Capture and pop in the same cycle SHALL be legal at any occupancy, including count == DEPTH; count unchanged.
REQ-022 When count == 0 all outputs except lookup_ready_o (=1) SHALL be 0; a captured entry SHALL become visible the cycle after capture.
REQ-023 Occupancy state SHALL be EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); transitions only by ±1 per cycle; for DEPTH==1 PARTIAL SHALL be unreachable.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-025 invalidate_i SHALL block capture only; already held entries SHALL remain and drain normally.
REQ-026 select_i >= NUM_PORTS SHALL block capture.

Reset
REQ-027 On Rst_RBI low, count, pointers and all output registers SHALL clear to 0, state EMPTY; held entries are discarded.
REQ-028 Reset assertion mid-operation SHALL take effect without a clock edge; first capture allowed on the first rising edge after deassertion.

Structure
REQ-029 Package rab_lookup_pkg SHALL hold the result entry struct typedef and the occupancy state enum.
REQ-030 Storage and pointer logic SHALL be one sub-module, lookup_result_fifo, parametrised by DEPTH and entry type.

Verification
REQ-031 NUM_PORTS=2, DEPTH=1: port 1 hit, no_prot=1 -> next cycle port_accept_o=2'b10, sent[1] -> outputs 0 next cycle.
REQ-032 DEPTH=2: captures port0 no_hit then port1 multi_hit -> head drop=2'b01, miss_o=1; sent[1] ignored; sent[0] -> head drop=2'b10, multi_o=1.
REQ-033 Full (count 2) with sent on head port and new valid request same cycle -> lookup_ready_o=1, pending_o stays 2, order preserved.
REQ-034 invalidate_i=1 with valid request -> no capture, pending_o unchanged, held entries still drain.
REQ-035 DEPTH=3: 7 capture/pop pairs -> pointer wrap, in_id_o sequence matches capture order.
REQ-036 Rst_RBI low between edges with 2 entries -> all outputs 0 immediately, pending_o=0.
